// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the two-master AXI4 read-channel arbiter.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Grant decision for the read arbiter. AXI_RD_ARB_RR_EN selects round-robin on
// contention; otherwise m1 always beats m0.
module axi_rd_arb_pick
    import axi_rd_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = GNT_M0;
`ifdef AXI_RD_ARB_RR_EN
        // On contention the master that did not win last time goes first.
        if (&req)
            gnt_idx = ~last_grant;
        else if (req[1])
            gnt_idx = GNT_M1;
`else
        if (req[1])
            gnt_idx = GNT_M1;
`endif
    end

`ifndef AXI_RD_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter (AR/R), one grant per burst.
// Build option AXI_RD_ARB_RR_EN: round-robin instead of fixed m1-over-m0 priority.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              rst_n_sync,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [LEN_W-1:0]  m0_arlen,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [LEN_W-1:0]  m1_arlen,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [LEN_W-1:0]  s_arlen,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    output logic              o_busy,
    output logic              o_err
);

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
    logic             err_q, err_d;

    logic             last_grant;
    logic             pick_idx, pick_vld;
    logic             r_hs;

`ifdef AXI_RD_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b0;
`endif

    axi_rd_arb_pick u_pick (
        .req        ({m1_arvalid, m0_arvalid}),
        .last_grant (last_grant),
        .gnt_idx    (pick_idx),
        .gnt_vld    (pick_vld)
    );

    // Channel routing is purely a function of state and grantee, so an
    // asynchronous reset silences every output in the same instant.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = '0;
        m1_rresp   = '0;
        m0_rlast   = 1'b0;
        m1_rlast   = 1'b0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_rready   = 1'b0;
        case (state_q)
            ADDR: begin
                s_arvalid = 1'b1;
                if (gnt_q == GNT_M1) begin
                    s_araddr   = m1_araddr;
                    s_arlen    = m1_arlen;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arlen    = m0_arlen;
                    m0_arready = s_arready;
                end
            end
            DATA: begin
                if (gnt_q == GNT_M1) begin
                    s_rready  = m1_rready;
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    s_rready  = m0_rready;
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

    assign r_hs = (state_q == DATA) && s_rvalid && s_rready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
`ifdef AXI_RD_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    len_d   = (pick_idx == GNT_M1) ? m1_arlen : m0_arlen;
                    state_d = ADDR;
`ifdef AXI_RD_ARB_RR_EN
                    last_grant_d = pick_idx;
`endif
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_d    = DATA;
                    beat_cnt_d = '0;
                end
            end
            DATA: begin
                if (r_hs) begin
                    if (beat_cnt_q != '1)
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    // RLAST must coincide exactly with the beat numbered arlen.
                    if (s_rlast != (beat_cnt_q == {1'b0, len_q}))
                        err_d = 1'b1;
                    if (s_rlast)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_M0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            last_grant_q <= GNT_M0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
`ifdef AXI_RD_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_err  = err_q;

endmodule
